// File: rtl/rename_alloc_ctrl_pkg.sv
// rtl/rename_alloc_ctrl_pkg.sv - shared constants, recovery state encoding and request helper for rename allocation
package rename_alloc_ctrl_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int PHY_REG_SEL  = 6;
    localparam int ARCH_REG_NUM = 32;
    localparam int RECOVER_LAT  = 2;
    localparam int CNT_W        = 2;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rec_state_t;

    // Number of destination tags a dispatch pair needs (0..2).
    function automatic logic [1:0] calc_reqnum(
        input logic invalid1,
        input logic wr_reg_1,
        input logic invalid2,
        input logic wr_reg_2
    );
        return {1'b0, ~invalid1 & wr_reg_1} + {1'b0, ~invalid2 & wr_reg_2};
    endfunction

endpackage

// File: rtl/rename_alloc_ctrl_fsm.sv
// rtl/rename_alloc_ctrl_fsm.sv - misprediction recovery sequencer (state + countdown) for rename allocation
module alloc_recover_fsm
    import rename_alloc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic prmiss,
    output logic in_run
);

    rec_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A new misprediction always restarts the countdown, even mid-recovery.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (prmiss) begin
            state_nxt = RECOVER;
            cnt_nxt   = CNT_W'(RECOVER_LAT - 1);
        end else if (state == RECOVER) begin
            if (cnt == '0) begin
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    assign in_run = (state == RUN);

endmodule

// File: rtl/rename_alloc_ctrl.sv
// rtl/rename_alloc_ctrl.sv - 2-wide rename tag allocation control; FREELIST_BYPASS_EN lets same-cycle commits feed pops
module rename_alloc_ctrl
    import rename_alloc_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   invalid1,
    input  logic                   invalid2,
    input  logic                   wr_reg_1,
    input  logic                   wr_reg_2,
    input  logic                   stall_in,
    input  logic [1:0]             comnum,
    input  logic                   prmiss,
    input  logic [PHY_REG_SEL:0]   rec_freenum,
    output logic [1:0]             pop_num,
    output logic                   pop_sel2,
    output logic                   allocatable,
    output logic                   stall_DP,
    output logic [PHY_REG_SEL:0]   freenum,
    output logic                   err_overflow
);

    localparam int WW = PHY_REG_SEL + 2;

    logic          in_run;
    logic [1:0]    reqnum;
    logic [WW-1:0] avail;
    logic [WW-1:0] comnum_w;
    logic [WW-1:0] freenum_raw;
    logic          grant;
    logic          overflow;

    alloc_recover_fsm u_fsm (
        .clk    (clk),
        .reset  (reset),
        .prmiss (prmiss),
        .in_run (in_run)
    );

    assign reqnum   = calc_reqnum(invalid1, wr_reg_1, invalid2, wr_reg_2);
    assign comnum_w = {{PHY_REG_SEL{1'b0}}, comnum};

`ifdef FREELIST_BYPASS_EN
    assign avail = {1'b0, freenum} + comnum_w;
`else
    assign avail = {1'b0, freenum};
`endif

    assign allocatable = in_run && (avail >= {{PHY_REG_SEL{1'b0}}, reqnum});
    // A misprediction cycle never grants, whatever the current state.
    assign grant       = allocatable & ~stall_in & ~prmiss;
    assign stall_DP    = ~grant & ((reqnum != 2'd0) | ~in_run);
    assign pop_num     = grant ? reqnum : 2'd0;
    assign pop_sel2    = ~invalid1 & wr_reg_1;

    always_comb begin
        freenum_raw = '0;
        if (prmiss) begin
            freenum_raw = {1'b0, rec_freenum} + comnum_w;
        end else begin
            freenum_raw = {1'b0, freenum} + comnum_w - {{PHY_REG_SEL{1'b0}}, pop_num};
        end
    end

    assign overflow = (freenum_raw > WW'(PHY_REG_NUM));

    always_ff @(posedge clk) begin
        if (reset) begin
            freenum      <= (PHY_REG_SEL+1)'(PHY_REG_NUM - ARCH_REG_NUM);
            err_overflow <= 1'b0;
        end else begin
            freenum <= overflow ? (PHY_REG_SEL+1)'(PHY_REG_NUM) : freenum_raw[PHY_REG_SEL:0];
            if (overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb/tb_rename_alloc_ctrl.sv - directed self-checking bench for rename_alloc_ctrl (honours FREELIST_BYPASS_EN)
module tb_rename_alloc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       invalid1, invalid2, wr_reg_1, wr_reg_2;
    logic       stall_in;
    logic [1:0] comnum;
    logic       prmiss;
    logic [6:0] rec_freenum;
    logic [1:0] pop_num;
    logic       pop_sel2, allocatable, stall_DP, err_overflow;
    logic [6:0] freenum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rename_alloc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .invalid1     (invalid1),
        .invalid2     (invalid2),
        .wr_reg_1     (wr_reg_1),
        .wr_reg_2     (wr_reg_2),
        .stall_in     (stall_in),
        .comnum       (comnum),
        .prmiss       (prmiss),
        .rec_freenum  (rec_freenum),
        .pop_num      (pop_num),
        .pop_sel2     (pop_sel2),
        .allocatable  (allocatable),
        .stall_DP     (stall_DP),
        .freenum      (freenum),
        .err_overflow (err_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        invalid1 = 1'b1; invalid2 = 1'b1;
        wr_reg_1 = 1'b0; wr_reg_2 = 1'b0;
        stall_in = 1'b0; comnum = 2'd0;
        prmiss = 1'b0; rec_freenum = 7'd0;
    endtask

    task automatic req_both();
        invalid1 = 1'b0; invalid2 = 1'b0;
        wr_reg_1 = 1'b1; wr_reg_2 = 1'b1;
    endtask

    task automatic do_recover(input logic [6:0] rec);
        prmiss = 1'b1; rec_freenum = rec;
        tick();
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (freenum !== 7'd32) begin failures++; $display("FAIL reset_freenum got=%0d exp=32", freenum); end
        checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL reset_alloc got=%b exp=1", allocatable); end
        checks++; if (pop_num !== 2'd0) begin failures++; $display("FAIL reset_pop got=%0d exp=0", pop_num); end
        checks++; if (stall_DP !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_DP); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overflow); end
    endtask

    task automatic test_dual_alloc();
        req_both();
        #1;
        checks++; if (pop_num !== 2'd2) begin failures++; $display("FAIL dual_pop got=%0d exp=2", pop_num); end
        checks++; if (pop_sel2 !== 1'b1) begin failures++; $display("FAIL dual_sel2 got=%b exp=1", pop_sel2); end
        checks++; if (stall_DP !== 1'b0) begin failures++; $display("FAIL dual_stall got=%b exp=0", stall_DP); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd30) begin failures++; $display("FAIL dual_freenum got=%0d exp=30", freenum); end
    endtask

    task automatic test_slot2_only();
        invalid2 = 1'b0; wr_reg_2 = 1'b1;
        #1;
        checks++; if (pop_num !== 2'd1) begin failures++; $display("FAIL slot2_pop got=%0d exp=1", pop_num); end
        checks++; if (pop_sel2 !== 1'b0) begin failures++; $display("FAIL slot2_sel2 got=%b exp=0", pop_sel2); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd29) begin failures++; $display("FAIL slot2_freenum got=%0d exp=29", freenum); end
    endtask

    task automatic test_stall_in();
        req_both();
        stall_in = 1'b1;
        #1;
        checks++; if (pop_num !== 2'd0) begin failures++; $display("FAIL stallin_pop got=%0d exp=0", pop_num); end
        checks++; if (stall_DP !== 1'b1) begin failures++; $display("FAIL stallin_stall got=%b exp=1", stall_DP); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd29) begin failures++; $display("FAIL stallin_freenum got=%0d exp=29", freenum); end
    endtask

    task automatic test_commit_and_pop();
        invalid1 = 1'b0; wr_reg_1 = 1'b1; comnum = 2'd2;
        #1;
        checks++; if (pop_num !== 2'd1) begin failures++; $display("FAIL compop_pop got=%0d exp=1", pop_num); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd30) begin failures++; $display("FAIL compop_freenum got=%0d exp=30", freenum); end
    endtask

    task automatic test_prmiss();
        req_both();
        prmiss = 1'b1; rec_freenum = 7'd20; comnum = 2'd1;
        #1;
        checks++; if (pop_num !== 2'd0) begin failures++; $display("FAIL prmiss_pop got=%0d exp=0", pop_num); end
        checks++; if (stall_DP !== 1'b1) begin failures++; $display("FAIL prmiss_stall got=%b exp=1", stall_DP); end
        tick();
        prmiss = 1'b0; comnum = 2'd0;
        #1;
        checks++; if (freenum !== 7'd21) begin failures++; $display("FAIL prmiss_freenum got=%0d exp=21", freenum); end
        checks++; if (allocatable !== 1'b0) begin failures++; $display("FAIL rec1_alloc got=%b exp=0", allocatable); end
        checks++; if (pop_num !== 2'd0) begin failures++; $display("FAIL rec1_pop got=%0d exp=0", pop_num); end
        tick();
        checks++; if (allocatable !== 1'b0) begin failures++; $display("FAIL rec2_alloc got=%b exp=0", allocatable); end
        checks++; if (stall_DP !== 1'b1) begin failures++; $display("FAIL rec2_stall got=%b exp=1", stall_DP); end
        tick();
        checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL rec_done_alloc got=%b exp=1", allocatable); end
        checks++; if (pop_num !== 2'd2) begin failures++; $display("FAIL rec_done_pop got=%0d exp=2", pop_num); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd19) begin failures++; $display("FAIL rec_done_freenum got=%0d exp=19", freenum); end
    endtask

    task automatic test_prmiss_restart();
        prmiss = 1'b1; rec_freenum = 7'd10;
        tick();
        prmiss = 1'b0;
        tick();
        prmiss = 1'b1; rec_freenum = 7'd12;
        tick();
        prmiss = 1'b0;
        #1;
        checks++; if (freenum !== 7'd12) begin failures++; $display("FAIL restart_freenum got=%0d exp=12", freenum); end
        checks++; if (allocatable !== 1'b0) begin failures++; $display("FAIL restart1_alloc got=%b exp=0", allocatable); end
        tick();
        checks++; if (allocatable !== 1'b0) begin failures++; $display("FAIL restart2_alloc got=%b exp=0", allocatable); end
        tick();
        checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL restart_done_alloc got=%b exp=1", allocatable); end
        set_idle();
    endtask

    task automatic test_bypass();
        do_recover(7'd1);
        req_both();
        comnum = 2'd1;
        #1;
`ifdef FREELIST_BYPASS_EN
        checks++; if (pop_num !== 2'd2) begin failures++; $display("FAIL bypass_pop got=%0d exp=2", pop_num); end
        checks++; if (stall_DP !== 1'b0) begin failures++; $display("FAIL bypass_stall got=%b exp=0", stall_DP); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd0) begin failures++; $display("FAIL bypass_freenum got=%0d exp=0", freenum); end
`else
        checks++; if (pop_num !== 2'd0) begin failures++; $display("FAIL nobypass_pop got=%0d exp=0", pop_num); end
        checks++; if (stall_DP !== 1'b1) begin failures++; $display("FAIL nobypass_stall got=%b exp=1", stall_DP); end
        tick();
        set_idle();
        checks++; if (freenum !== 7'd2) begin failures++; $display("FAIL nobypass_freenum got=%0d exp=2", freenum); end
`endif
    endtask

    task automatic test_overflow();
        do_recover(7'd64);
        checks++; if (freenum !== 7'd64) begin failures++; $display("FAIL ovf_pre_freenum got=%0d exp=64", freenum); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre_err got=%b exp=0", err_overflow); end
        comnum = 2'd1;
        tick();
        comnum = 2'd0;
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", err_overflow); end
        checks++; if (freenum !== 7'd64) begin failures++; $display("FAIL ovf_freenum got=%0d exp=64", freenum); end
        tick();
        tick();
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", err_overflow); end
    endtask

    task automatic test_reset_mid_recover();
        prmiss = 1'b1; rec_freenum = 7'd5;
        tick();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (freenum !== 7'd32) begin failures++; $display("FAIL midrst_freenum got=%0d exp=32", freenum); end
        checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL midrst_alloc got=%b exp=1", allocatable); end
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", err_overflow); end
        req_both();
        #1;
        checks++; if (pop_num !== 2'd2) begin failures++; $display("FAIL midrst_pop got=%0d exp=2", pop_num); end
        tick();
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_dual_alloc();
        test_slot2_only();
        test_stall_in();
        test_commit_and_pop();
        test_prmiss();
        test_prmiss_restart();
        test_bypass();
        test_overflow();
        test_reset_mid_recover();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
